// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared memory-handshake encodings for the control unit and ram_controller
package mem_pkg;

  localparam logic [1:0] DL_BYTE = 2'b00;
  localparam logic [1:0] DL_HALF = 2'b01;
  localparam logic [1:0] DL_WORD = 2'b10;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ACCESS,
    ST_DONE
  } mem_state_e;

  // DL=11 behaves as a word, so anything that is not byte/half needs 4-byte alignment.
  function automatic logic misaligned(input logic [1:0] dl, input logic [1:0] a);
    case (dl)
      DL_BYTE: return 1'b0;
      DL_HALF: return a[0];
      default: return a != 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/ram_controller_if.sv
// rtl/ram_controller_if.sv - MOV/MOC memory handshake bundle between control unit and RAM
interface ram_controller_if;

  logic        MOV;
  logic        RW;
  logic [1:0]  DL;
  logic        SIG;
  logic [31:0] address;
  logic [31:0] data_in;
  logic [31:0] data_out;
  logic        MOC;
  logic        align_err;

  modport master (
    output MOV, RW, DL, SIG, address, data_in,
    input  data_out, MOC, align_err
  );

  modport slave (
    input  MOV, RW, DL, SIG, address, data_in,
    output data_out, MOC, align_err
  );

endinterface

// File: rtl/byte_lane_formatter.sv
// rtl/byte_lane_formatter.sv - big-endian lane mapping for reads (with extension) and writes
module byte_lane_formatter
  import mem_pkg::*;
(
  input  logic [1:0]  dl,
  input  logic        sig,
  input  logic [31:0] rd_lanes,
  input  logic [31:0] wr_data,
  output logic [31:0] rd_data,
  output logic [3:0]  byte_en,
  output logic [31:0] wr_lanes
);

  // Lane 0 ([31:24], byte_en[3]) is the byte at the access address; later lanes follow it.
  always_comb begin
    rd_data  = rd_lanes;
    byte_en  = 4'b1111;
    wr_lanes = wr_data;
    case (dl)
      DL_BYTE: begin
        rd_data  = {{24{sig & rd_lanes[31]}}, rd_lanes[31:24]};
        byte_en  = 4'b1000;
        wr_lanes = {wr_data[7:0], 24'h0};
      end
      DL_HALF: begin
        rd_data  = {{16{sig & rd_lanes[31]}}, rd_lanes[31:16]};
        byte_en  = 4'b1100;
        wr_lanes = {wr_data[15:0], 16'h0};
      end
      default: begin
        rd_data  = rd_lanes;
        byte_en  = 4'b1111;
        wr_lanes = wr_data;
      end
    endcase
  end

endmodule

// File: rtl/ram_controller.sv
// rtl/ram_controller.sv - wait-stated big-endian byte RAM answering MOV with MOC
// Optional misalignment trap: RAM_CONTROLLER_ALIGN_CHECK_EN
module ram_controller
  import mem_pkg::*;
#(
  parameter int DEPTH       = 512,
  parameter int WAIT_CYCLES = 2
) (
  input logic            clk,
  input logic            reset,
  ram_controller_if.slave bus
);

  localparam int AW = $clog2(DEPTH);

  mem_state_e    state_q, state_d;
  logic [15:0]   cnt_q, cnt_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          rw_q, rw_d;
  logic [1:0]    dl_q, dl_d;
  logic          sig_q, sig_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          mis_q, mis_d;
  logic          moc_q, moc_d;
  logic          aerr_q, aerr_d;
  logic [31:0]   dout_q, dout_d;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] addr_p1, addr_p2, addr_p3;
  logic [31:0]   rd_lanes, rd_data, wr_lanes;
  logic [3:0]    byte_en;
  logic          mis_cap, mem_we;
  logic          unused_addr_hi;

  // Truncating to AW bits gives the mod-DEPTH wrap for free.
  assign addr_p1  = addr_q + AW'(1);
  assign addr_p2  = addr_q + AW'(2);
  assign addr_p3  = addr_q + AW'(3);
  assign rd_lanes = {mem[addr_q], mem[addr_p1], mem[addr_p2], mem[addr_p3]};
  assign unused_addr_hi = ^bus.address[31:AW];

`ifdef RAM_CONTROLLER_ALIGN_CHECK_EN
  assign mis_cap = misaligned(bus.DL, bus.address[1:0]);
`else
  assign mis_cap = 1'b0;
`endif

  byte_lane_formatter u_fmt (
    .dl      (dl_q),
    .sig     (sig_q),
    .rd_lanes(rd_lanes),
    .wr_data (wdata_q),
    .rd_data (rd_data),
    .byte_en (byte_en),
    .wr_lanes(wr_lanes)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    rw_d    = rw_q;
    dl_d    = dl_q;
    sig_d   = sig_q;
    wdata_d = wdata_q;
    mis_d   = mis_q;
    moc_d   = moc_q;
    aerr_d  = aerr_q;
    dout_d  = dout_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.MOV) begin
          addr_d  = bus.address[AW-1:0];
          rw_d    = bus.RW;
          dl_d    = bus.DL;
          sig_d   = bus.SIG;
          wdata_d = bus.data_in;
          mis_d   = mis_cap;
          if (WAIT_CYCLES == 0) begin
            state_d = ST_ACCESS;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = 16'(WAIT_CYCLES - 1);
          end
        end
      end
      ST_WAIT: begin
        if (!bus.MOV) begin
          state_d = ST_IDLE;
          cnt_d   = 16'd0;
        end else if (cnt_q == 16'd0) begin
          state_d = ST_ACCESS;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      ST_ACCESS: begin
        state_d = ST_DONE;
        moc_d   = 1'b1;
        aerr_d  = mis_q;
        if (rw_q == RW_READ) begin
          dout_d = mis_q ? 32'h0 : rd_data;
        end
      end
      ST_DONE: begin
        if (!bus.MOV) begin
          state_d = ST_IDLE;
          moc_d   = 1'b0;
          aerr_d  = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign mem_we = (state_q == ST_ACCESS) && (rw_q == RW_WRITE) && !mis_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= 16'd0;
      addr_q  <= '0;
      rw_q    <= 1'b0;
      dl_q    <= 2'b00;
      sig_q   <= 1'b0;
      wdata_q <= 32'h0;
      mis_q   <= 1'b0;
      moc_q   <= 1'b0;
      aerr_q  <= 1'b0;
      dout_q  <= 32'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      rw_q    <= rw_d;
      dl_q    <= dl_d;
      sig_q   <= sig_d;
      wdata_q <= wdata_d;
      mis_q   <= mis_d;
      moc_q   <= moc_d;
      aerr_q  <= aerr_d;
      dout_q  <= dout_d;
    end
  end

  // RAM keeps its contents across reset; commits on the ACCESS->DONE edge.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      if (byte_en[3]) mem[addr_q]  <= wr_lanes[31:24];
      if (byte_en[2]) mem[addr_p1] <= wr_lanes[23:16];
      if (byte_en[1]) mem[addr_p2] <= wr_lanes[15:8];
      if (byte_en[0]) mem[addr_p3] <= wr_lanes[7:0];
    end
  end

  assign bus.MOC       = moc_q;
  assign bus.data_out  = dout_q;
  assign bus.align_err = aerr_q;

endmodule

// File: tb/tb_ram_controller.sv
// tb/tb_ram_controller.sv - randomized self-checking bench for ram_controller against a byte-array model
`timescale 1ns/1ps
module tb_ram_controller;
  import mem_pkg::*;

  localparam int DEPTH = 512;
  localparam int W     = 2;
`ifdef RAM_CONTROLLER_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  ram_controller_if bus ();

  ram_controller #(.DEPTH(DEPTH), .WAIT_CYCLES(W)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [7:0]  mmem [DEPTH];
  logic [31:0] exp_dout;
  logic        exp_moc, exp_aerr;
  bit          cmp_en;
  logic        aerr_seen;
  logic [31:0] prev;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic void model_apply(input logic rw, input logic [1:0] dl, input logic sig,
                                      input logic [31:0] addr, input logic [31:0] data);
    int n = (dl == 2'b00) ? 1 : (dl == 2'b01) ? 2 : 4;
    int a = int'(addr % 32'(DEPTH));
    bit mis = ALIGN && ((n == 2 && addr[0]) || (n == 4 && addr[1:0] != 2'b00));
    longint unsigned v = 0;
    exp_aerr = mis;
    if (rw) begin
      if (mis) begin
        exp_dout = 32'h0;
      end else begin
        for (int i = 0; i < n; i++) v = v * 256 + longint'(mmem[(a + i) % DEPTH]);
        if (sig && v[8*n-1]) v = v | (64'hFFFF_FFFF_FFFF_FFFF << (8 * n));
        exp_dout = v[31:0];
      end
    end else if (!mis) begin
      for (int i = 0; i < n; i++) mmem[(a + i) % DEPTH] = 8'(data >> (8 * (n - 1 - i)));
    end
  endfunction

  // One full MOV/MOC transaction; operands are scrambled right after capture.
  task automatic op(input logic rw, input logic [1:0] dl, input logic sig,
                    input logic [31:0] addr, input logic [31:0] data, input int hold);
    int first = 0;
    @(negedge clk);
    bus.MOV = 1'b1; bus.RW = rw; bus.DL = dl; bus.SIG = sig;
    bus.address = addr; bus.data_in = data;
    for (int k = 1; k <= W + 2 + hold; k++) begin
      @(posedge clk);
      if (k == W + 2) begin
        model_apply(rw, dl, sig, addr, data);
        exp_moc = 1'b1;
      end
      @(negedge clk);
      if (k == 1) begin
        bus.address = $urandom; bus.data_in = $urandom;
        bus.DL = 2'($urandom); bus.RW = 1'($urandom); bus.SIG = 1'($urandom);
      end
      if (bus.MOC === 1'b1 && first == 0) begin
        first     = k;
        aerr_seen = bus.align_err;
      end
    end
    bus.MOV = 1'b0;
    @(posedge clk);
    exp_moc  = 1'b0;
    exp_aerr = 1'b0;
    check("latency", 32'(first - 1), 32'(W + 1));
  endtask

  always @(negedge clk) begin
    if (cmp_en && reset) begin
      check("moc", {31'b0, bus.MOC}, {31'b0, exp_moc});
      check("data_out", bus.data_out, exp_dout);
      check("align_err", {31'b0, bus.align_err}, {31'b0, exp_aerr});
    end
  end

  initial begin
    cmp_en = 1'b0;
    exp_dout = 32'h0; exp_moc = 1'b0; exp_aerr = 1'b0; aerr_seen = 1'b0;
    bus.MOV = 1'b0; bus.RW = 1'b0; bus.DL = 2'b00; bus.SIG = 1'b0;
    bus.address = 32'h0; bus.data_in = 32'h0;
    repeat (3) @(negedge clk);
    check("rst_moc", {31'b0, bus.MOC}, 32'h0);
    check("rst_dout", bus.data_out, 32'h0);
    check("rst_aerr", {31'b0, bus.align_err}, 32'h0);
    reset  = 1'b1;
    cmp_en = 1'b1;

    for (int a = 0; a < DEPTH; a += 4) op(RW_WRITE, DL_WORD, 1'b0, 32'(a), $urandom, 0);

    op(RW_WRITE, DL_WORD, 1'b0, 32'h10, 32'hDEADBEEF, 0);
    op(RW_READ,  DL_WORD, 1'b0, 32'h10, 32'h0, 0);
    check("word_rd", bus.data_out, 32'hDEADBEEF);
    op(RW_READ,  DL_BYTE, 1'b1, 32'h10, 32'h0, 0);
    check("byte_sext", bus.data_out, 32'hFFFFFFDE);
    op(RW_READ,  DL_BYTE, 1'b0, 32'h10, 32'h0, 5);
    check("byte_zext_hold", bus.data_out, 32'h000000DE);

    op(RW_WRITE, DL_WORD, 1'b0, 32'h20, 32'hCAFEF00D, 0);
    op(RW_WRITE, DL_HALF, 1'b0, 32'h20, 32'hABCD1234, 0);
    op(RW_READ,  DL_HALF, 1'b1, 32'h20, 32'h0, 0);
    check("half_pos", bus.data_out, 32'h00001234);
    op(RW_WRITE, DL_HALF, 1'b0, 32'h20, 32'h77778001, 0);
    op(RW_READ,  DL_HALF, 1'b1, 32'h20, 32'h0, 0);
    check("half_neg", bus.data_out, 32'hFFFF8001);
    op(RW_READ,  DL_BYTE, 1'b0, 32'h22, 32'h0, 0);
    check("half_nb22", bus.data_out, 32'h000000F0);
    op(RW_READ,  DL_BYTE, 1'b0, 32'h23, 32'h0, 0);
    check("half_nb23", bus.data_out, 32'h0000000D);

    op(RW_WRITE, DL_WORD, 1'b0, 32'(DEPTH - 2), 32'hA1B2C3D4, 0);
    op(RW_READ,  DL_BYTE, 1'b0, 32'(DEPTH - 2), 32'h0, 0);
    check("wrap_b0", bus.data_out, 32'h000000A1);
    op(RW_READ,  DL_BYTE, 1'b0, 32'(DEPTH - 1), 32'h0, 0);
    check("wrap_b1", bus.data_out, 32'h000000B2);
    op(RW_READ,  DL_BYTE, 1'b0, 32'h0, 32'h0, 0);
    check("wrap_b2", bus.data_out, 32'h000000C3);
    op(RW_READ,  DL_BYTE, 1'b0, 32'h1, 32'h0, 0);
    check("wrap_b3", bus.data_out, 32'h000000D4);
    op(RW_READ,  DL_WORD, 1'b0, 32'(DEPTH * 8 + DEPTH - 2), 32'h0, 0);
    check("wrap_word", bus.data_out, 32'hA1B2C3D4);

    prev = {mmem[8'h40], mmem[8'h41], mmem[8'h42], mmem[8'h43]};
    @(negedge clk);
    bus.MOV = 1'b1; bus.RW = RW_WRITE; bus.DL = DL_WORD; bus.address = 32'h40; bus.data_in = ~prev;
    @(negedge clk);
    bus.MOV = 1'b0;
    repeat (5) @(negedge clk);
    op(RW_READ, DL_WORD, 1'b0, 32'h40, 32'h0, 0);
    check("abort_nowrite", bus.data_out, prev);

    op(RW_READ, DL_WORD, 1'b0, 32'h10, 32'h0, 0);
    @(negedge clk);
    bus.MOV = 1'b1; bus.RW = RW_WRITE; bus.DL = DL_WORD; bus.address = 32'h10; bus.data_in = 32'h11111111;
    @(posedge clk);
    #2;
    reset    = 1'b0;
    exp_dout = 32'h0; exp_moc = 1'b0; exp_aerr = 1'b0;
    #1;
    check("rstmid_moc", {31'b0, bus.MOC}, 32'h0);
    check("rstmid_dout", bus.data_out, 32'h0);
    @(negedge clk);
    bus.MOV = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    op(RW_READ, DL_WORD, 1'b0, 32'h10, 32'h0, 0);
    check("rstmid_nowrite", bus.data_out, 32'hDEADBEEF);

    op(RW_WRITE, DL_WORD, 1'b0, 32'h10, 32'h0, 0);
    op(RW_WRITE, DL_WORD, 1'b0, 32'h14, 32'h0, 0);
    op(RW_WRITE, DL_WORD, 1'b0, 32'h11, 32'h55667788, 0);
    check("unaligned_flag", {31'b0, aerr_seen}, {31'b0, ALIGN});
    op(RW_READ, DL_BYTE, 1'b0, 32'h11, 32'h0, 0);
    check("unal_b11", bus.data_out, ALIGN ? 32'h0 : 32'h55);
    op(RW_READ, DL_BYTE, 1'b0, 32'h14, 32'h0, 0);
    check("unal_b14", bus.data_out, ALIGN ? 32'h0 : 32'h88);

    repeat (200) op(1'($urandom), 2'($urandom), 1'($urandom), $urandom, $urandom, $urandom_range(0, 3));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ram_controller.md
# ram_controller

Memory-side responder for the control unit's MOV/MOC handshake. Sits directly downstream of the control unit's memory signals (MOV, RW, DL, SIG) and the MAR/MDR registers. Holds a byte-addressed big-endian RAM and performs byte, halfword and word reads and writes after a programmable number of wait states. It returns MOC, which the control unit's condition mux samples to leave its memory-wait state.

## Interface

Parameters:
- DEPTH, 512: RAM size in bytes; power of two.
- WAIT_CYCLES, 2: wait states inserted before each access; 0 is legal.

Ports:
- clk  input  1  system clock; rising edge active
- reset  input  1  asynchronous, active-low reset
- MOV  input  1  memory operation valid; level, held by the control unit until MOC is seen
- RW  input  1  1 = read, 0 = write
- DL  input  2  data length: 00 byte, 01 halfword, 10 word, 11 treated as word
- SIG  input  1  read extension: 1 = sign-extend, 0 = zero-extend
- address  input  32  byte address from MAR
- data_in  input  32  write data from MDR, right-aligned
- data_out  output  32  read data to MDR, right-aligned and extended
- MOC  output  1  memory operation complete
- align_err  output  1  misaligned-access flag (see Configuration)

## Operation

- FSM states: IDLE, WAIT, ACCESS, DONE.
- IDLE:
  - If MOV=1, capture address mod DEPTH, RW, DL, SIG and data_in.
  - Go to WAIT, or directly to ACCESS if WAIT_CYCLES=0.
- WAIT:
  - A down-counter loaded with WAIT_CYCLES-1 decrements each cycle.
  - At 0, go to ACCESS.
  - MOV falling during WAIT aborts the operation: return to IDLE, no RAM write, MOC stays 0.
- ACCESS:
  - Write: store the low 1, 2 or 4 bytes of the captured data big-endian at addr..addr+n-1.
  - Read: assemble the same bytes into data_out, extended per SIG.
  - Go to DONE.
- DONE:
  - MOC=1; hold while MOV=1.
  - When MOV=0, drop MOC and return to IDLE next cycle.
  - A new request is not accepted until IDLE is re-entered.
- Address arithmetic wraps mod DEPTH, so a word at DEPTH-2 touches DEPTH-2, DEPTH-1, 0 and 1.
- Captured operands are used throughout. Changes to address or data_in after capture are ignored.

## Timing

- Reset (reset=0, asynchronous):
  - State goes to IDLE; MOC=0, data_out=0, align_err=0, counter=0.
  - RAM contents are not cleared.
- Latency: MOV sampled high at edge N gives MOC=1 after edge N+WAIT_CYCLES+1.
- Read data_out is registered and valid in the same cycle MOC rises. It holds until the next completed read.
- Write commits at the edge entering DONE.
- MOC is registered and glitch-free. It goes low the cycle after MOV=0 is sampled in DONE.
- Reset asserted mid-operation: the operation is abandoned. A pending write is not committed unless its commit edge preceded reset.

## Configuration

- Macro: RAM_CONTROLLER_ALIGN_CHECK_EN.
- Defined:
  - At capture, flag halfword with address[0]=1 and word with address[1:0]≠0.
  - A flagged access skips the RAM write and returns data_out=0 for reads.
  - It still completes with normal MOC timing.
  - align_err=1 in DONE, cleared on return to IDLE.
- Undefined:
  - No check; unaligned accesses proceed with wrap rules.
  - align_err tied 0.

## Structure

- Shared package mem_pkg holds:
  - DL encodings (DL_BYTE, DL_HALF, DL_WORD)
  - FSM state encoding
  - the RW_READ/RW_WRITE constants
- The control unit also uses mem_pkg.
- One sub-module: byte_lane_formatter, combinational.
  - Maps DL/SIG plus the RAM bytes to data_out.
  - Maps data_in to byte write-enables and lane data.

## Test plan

- Word write then read: write 0xDEADBEEF to 0x10, then read word at 0x10 → data_out=0xDEADBEEF; byte 0x10 = 0xDE; MOC high exactly WAIT_CYCLES+1 edges after MOV sampled.
- Byte read with extension: memory[0x10]=0xDE; SIG=1 → 0xFFFFFFDE; SIG=0 → 0x000000DE.
- Halfword: write 0x1234 to 0x20; read with SIG=1 → 0x00001234; write 0x8001 and read SIG=1 → 0xFFFF8001; neighbouring bytes 0x22/0x23 unchanged.
- Wrap: word write 0xA1B2C3D4 at DEPTH-2 → bytes DEPTH-2, DEPTH-1, 0, 1 = A1, B2, C3, D4.
- Handshake: MOV held 5 cycles past MOC → MOC held; MOV drop → MOC 0 next cycle; MOV dropped mid-WAIT → no write, MOC never rises; reset mid-WAIT → MOC=0, data_out=0 immediately.
- With RAM_CONTROLLER_ALIGN_CHECK_EN: word write at 0x11 → align_err=1 with MOC, RAM unchanged. Without the macro: same access writes bytes 0x11–0x14.
